// File: rtl/boot_frame_loader_pkg.sv
// Shared definitions for the boot loader back end.
//   boot_state_t          : frame parser / write handshake states
//   CMD_DONE_BIT          : CMD bit that marks end-of-load
//   DEFAULT_NARROW_BYTES  : default bytes per narrow word
//   DEFAULT_WIDE_BYTES    : default bytes per wide word
//   I_MEM/D_MEM/IMAGE_BUFFER : one-hot destination codes
//   cmd_dest_ok()         : CMD destination field check
package boot_frame_loader_pkg;

  typedef enum logic [2:0] {
    CMD,
    ADDR_LO,
    ADDR_HI,
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    DONE
  } boot_state_t;

  localparam int unsigned CMD_DONE_BIT         = 7;
  localparam int unsigned DEFAULT_NARROW_BYTES = 4;
  localparam int unsigned DEFAULT_WIDE_BYTES   = 384;

  localparam logic [2:0] I_MEM        = 3'b100;
  localparam logic [2:0] D_MEM        = 3'b010;
  localparam logic [2:0] IMAGE_BUFFER = 3'b001;

  // True when the destination field holds exactly one set bit and every
  // bit outside that field is clear.
  function automatic logic cmd_dest_ok(input logic [7:0] cmd,
                                       input logic [7:0] field);
    logic [7:0] sel;
    sel = cmd & field;
    return ((cmd & ~field) == 8'h00) && (sel != 8'h00) &&
           ((sel & (sel - 8'h01)) == 8'h00);
  endfunction

endpackage

// File: rtl/boot_frame_loader.sv
// Boot loader back end: parses framed bytes from the UART receiver and
// assembles them into words that are written to one of NUM_DEST targets.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   rx_valid/rx_data      : incoming byte stream
//   rx_ready              : byte accepted this cycle when rx_valid is high
//   wr_en/wr_ready        : write request held until accepted
//   wr_dest/wr_addr/wr_data : one-hot target, word address, assembled word
//                            (first byte of the word in bits [7:0])
//   done                  : sticky, end-of-load command received
//   err                   : sticky, malformed command received
module boot_frame_loader
  import boot_frame_loader_pkg::*;
#(
  parameter int unsigned          NUM_DEST     = 3,
  parameter int unsigned          NARROW_BYTES = DEFAULT_NARROW_BYTES,
  parameter int unsigned          WIDE_BYTES   = DEFAULT_WIDE_BYTES,
  parameter logic [NUM_DEST-1:0]  WIDE_MASK    = IMAGE_BUFFER,
  parameter int unsigned          ADDRW        = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data,
  output logic                    rx_ready,
  output logic                    wr_en,
  input  logic                    wr_ready,
  output logic [NUM_DEST-1:0]     wr_dest,
  output logic [ADDRW-1:0]        wr_addr,
  output logic [WIDE_BYTES*8-1:0] wr_data,
  output logic                    done,
  output logic                    err
);

  localparam int unsigned      LANEW       = $clog2(WIDE_BYTES);
  localparam logic [LANEW-1:0] NARROW_LAST = LANEW'(NARROW_BYTES - 1);
  localparam logic [LANEW-1:0] WIDE_LAST   = LANEW'(WIDE_BYTES - 1);
  localparam logic [7:0]       DEST_FIELD  = 8'((1 << NUM_DEST) - 1);

  boot_state_t      state;
  logic [LANEW-1:0] lane;
  logic [15:0]      remaining;
  logic [7:0]       addr_lo;
  logic [7:0]       len_lo;
  logic             wide;
  logic [LANEW-1:0] last_lane;

  assign last_lane = wide ? WIDE_LAST : NARROW_LAST;

  // rx_ready and wr_en are registered alongside every state change: rx_ready
  // drops only on entry to WRITE/DONE, wr_en is high exactly in WRITE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CMD;
      rx_ready  <= 1'b1;
      wr_en     <= 1'b0;
      wr_dest   <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      lane      <= '0;
      remaining <= '0;
      addr_lo   <= '0;
      len_lo    <= '0;
      wide      <= 1'b0;
    end else begin
      case (state)
        CMD: begin
          if (rx_valid) begin
            if (rx_data[CMD_DONE_BIT]) begin
              state    <= DONE;
              done     <= 1'b1;
              rx_ready <= 1'b0;
            end else if (cmd_dest_ok(rx_data, DEST_FIELD)) begin
              wr_dest <= rx_data[NUM_DEST-1:0];
              wide    <= |(rx_data[NUM_DEST-1:0] & WIDE_MASK);
              state   <= ADDR_LO;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ADDR_LO: begin
          if (rx_valid) begin
            addr_lo <= rx_data;
            state   <= ADDR_HI;
          end
        end
        ADDR_HI: begin
          if (rx_valid) begin
            wr_addr <= ADDRW'({rx_data, addr_lo});
            state   <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (rx_valid) begin
            len_lo <= rx_data;
            state  <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (rx_valid) begin
            remaining <= {rx_data, len_lo};
            lane      <= '0;
            wr_data   <= '0;
            state     <= ({rx_data, len_lo} == 16'h0000) ? CMD : DATA;
          end
        end
        DATA: begin
          if (rx_valid) begin
            wr_data[{lane, 3'b000} +: 8] <= rx_data;
            if (lane == last_lane) begin
              lane     <= '0;
              state    <= WRITE;
              rx_ready <= 1'b0;
              wr_en    <= 1'b1;
            end else begin
              lane <= lane + LANEW'(1);
            end
          end
        end
        WRITE: begin
          if (wr_ready) begin
            wr_en     <= 1'b0;
            rx_ready  <= 1'b1;
            wr_addr   <= wr_addr + ADDRW'(1);
            remaining <= remaining - 16'd1;
            wr_data   <= '0;
            state     <= (remaining == 16'd1) ? CMD : DATA;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state    <= CMD;
          rx_ready <= 1'b1;
          wr_en    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boot_frame_loader.sv
// Self-checking bench for boot_frame_loader: table-driven frames with a
// write scoreboard, plus hand-written stall, reset and done sequences.
module tb_boot_frame_loader;
  import boot_frame_loader_pkg::*;

  localparam int WB = 384;
  localparam int NB = 4;
  localparam int DW = WB * 8;
  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          wr_en;
  logic          wr_ready;
  logic [2:0]    wr_dest;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  boot_frame_loader #(
    .NUM_DEST(3), .NARROW_BYTES(NB), .WIDE_BYTES(WB),
    .WIDE_MASK(3'b001), .ADDRW(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .wr_en(wr_en), .wr_ready(wr_ready),
    .wr_dest(wr_dest), .wr_addr(wr_addr), .wr_data(wr_data),
    .done(done), .err(err)
  );

  typedef struct {
    logic [2:0]    dest;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t obs_q[$];
  int  checks = 0;
  int  errors = 0;
  int  wr_count = 0;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_data;

  // Record every write that will complete on the next rising edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wr_en === 1'b1 && wr_ready === 1'b1) begin
      obs_q.push_back('{dest: wr_dest, addr: wr_addr, data: wr_data});
      wr_count++;
    end
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_data(input string name, input logic [DW-1:0] act,
                            input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int i = 0; i < WB; i++) begin
        if (act[i*8 +: 8] !== exp[i*8 +: 8]) begin
          $display("FAIL %s: byte %0d got %0h expected %0h", name, i,
                   act[i*8 +: 8], exp[i*8 +: 8]);
          break;
        end
      end
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (rx_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n == 100) begin
      checks++;
      errors++;
      $display("FAIL rx_ready_timeout: got rx_ready=%0b expected 1", rx_ready);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_header(input logic [7:0] cmd, input logic [15:0] addr,
                             input logic [15:0] len);
    send_byte(cmd);
    send_byte(addr[7:0]);
    send_byte(addr[15:8]);
    send_byte(len[7:0]);
    send_byte(len[15:8]);
  endtask

  // Data byte k of a frame is (base + k*step) & mask.
  task automatic send_frame(input logic [7:0] cmd, input logic [15:0] addr,
                            input logic [15:0] len, input logic [7:0] base,
                            input logic [7:0] step, input logic [7:0] mask);
    int            wbytes;
    logic [AW-1:0] a0;
    wr_t           e;
    logic [7:0]    bytes[WB];
    wbytes = cmd[0] ? WB : NB;
    a0 = addr[AW-1:0];
    send_header(cmd, addr, len);
    for (int w = 0; w < int'(len); w++) begin
      e.dest = cmd[2:0];
      e.addr = a0 + AW'(w);
      e.data = '0;
      for (int i = 0; i < wbytes; i++) begin
        int v;
        v = int'(base) + (w * wbytes + i) * int'(step);
        bytes[i] = 8'(v) & mask;
        e.data[i*8 +: 8] = bytes[i];
      end
      exp_q.push_back(e);
      for (int i = 0; i < wbytes; i++) send_byte(bytes[i]);
    end
  endtask

  // Wait for all expected writes, then compare them in order.
  task automatic drain();
    int  n = 0;
    wr_t o;
    wr_t e;
    while (obs_q.size() < exp_q.size() && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check("wr_dest", 64'(o.dest), 64'(e.dest));
      check("wr_addr", 64'(o.addr), 64'(e.addr));
      check_data("wr_data", o.data, e.data);
      last_addr = o.addr;
      last_data = o.data;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL missing_write: got 0 writes expected %0d more", exp_q.size());
      exp_q.delete();
    end
    if (obs_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_write: got %0d extra writes expected 0", obs_q.size());
      obs_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        rst_before;
    logic        frame;
    logic [7:0]  cmd;
    logic [15:0] addr;
    logic [15:0] len;
    logic [7:0]  base;
    logic [7:0]  step;
    logic [7:0]  mask;
    int          exp_words;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int wc0;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    wr_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    check("reset_rx_ready", 64'(rx_ready), 64'd1);
    check("reset_wr_en",    64'(wr_en),    64'd0);
    check("reset_wr_dest",  64'(wr_dest),  64'd0);
    check("reset_wr_addr",  64'(wr_addr),  64'd0);
    check_data("reset_wr_data", wr_data, '0);
    check("reset_done",     64'(done),     64'd0);
    check("reset_err",      64'(err),      64'd0);

    //           rst   frame cmd    addr      len    base   step   mask   words err
    vecs[0] = '{1'b0, 1'b1, I_MEM, 16'h0010, 16'd2, 8'h11, 8'h11, 8'hFF, 2, 1'b0};
    vecs[1] = '{1'b0, 1'b1, IMAGE_BUFFER, 16'h0000, 16'd1, 8'h00, 8'h01, 8'h7F, 1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, D_MEM, 16'h7FFF, 16'd2, 8'hA0, 8'h03, 8'hFF, 2, 1'b0};
    vecs[3] = '{1'b0, 1'b1, I_MEM, 16'h1234, 16'd0, 8'h00, 8'h00, 8'hFF, 0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 8'h06, 16'h0000, 16'd0, 8'h00, 8'h00, 8'hFF, 0, 1'b1};
    vecs[5] = '{1'b0, 1'b1, D_MEM, 16'h8005, 16'd1, 8'h5A, 8'h01, 8'hFF, 1, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 8'h40, 16'h0000, 16'd0, 8'h00, 8'h00, 8'hFF, 0, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 8'h00, 16'h0000, 16'd0, 8'h00, 8'h00, 8'hFF, 0, 1'b1};
    vecs[8] = '{1'b1, 1'b0, 8'h03, 16'h0000, 16'd0, 8'h00, 8'h00, 8'hFF, 0, 1'b1};
    vecs[9] = '{1'b1, 1'b1, D_MEM, 16'hFFFF, 16'd1, 8'h10, 8'h07, 8'hFF, 1, 1'b0};

    for (int v = 0; v < 10; v++) begin
      if (vecs[v].rst_before) do_reset();
      wc0 = wr_count;
      if (vecs[v].frame)
        send_frame(vecs[v].cmd, vecs[v].addr, vecs[v].len,
                   vecs[v].base, vecs[v].step, vecs[v].mask);
      else
        send_byte(vecs[v].cmd);
      check($sformatf("v%0d_err", v), 64'(err), 64'(vecs[v].exp_err));
      drain();
      check($sformatf("v%0d_words", v), 64'(wr_count - wc0), 64'(vecs[v].exp_words));
      check($sformatf("v%0d_rx_ready", v), 64'(rx_ready), 64'd1);
      check($sformatf("v%0d_done", v), 64'(done), 64'd0);
      case (v)
        0: check("v0_last_word", 64'(last_data[63:0]), 64'h0000_0000_8877_6655);
        1: begin
          check("v1_first_byte", 64'(last_data[7:0]), 64'h00);
          check("v1_last_byte", 64'(last_data[3071:3064]), 64'h7F);
        end
        2: check("v2_wrap_addr", 64'(last_addr), 64'h0000);
        9: check("v9_addr", 64'(last_addr), 64'h7FFF);
        default: ;
      endcase
    end

    // Back-pressure: first word waits five cycles with wr_ready low.
    wr_ready = 1'b0;
    wc0 = wr_count;
    exp_q.push_back('{dest: I_MEM, addr: 15'h0020, data: DW'(32'h3433_3231)});
    exp_q.push_back('{dest: I_MEM, addr: 15'h0021, data: DW'(32'h3837_3635)});
    send_header(I_MEM, 16'h0020, 16'd2);
    for (int i = 0; i < 4; i++) send_byte(8'(8'h31 + i));
    for (int c = 0; c < 6; c++) begin
      check("stall_wr_en", 64'(wr_en), 64'd1);
      check("stall_rx_ready", 64'(rx_ready), 64'd0);
      check("stall_wr_addr", 64'(wr_addr), 64'h20);
      check("stall_wr_data", 64'(wr_data[63:0]), 64'h3433_3231);
      check("stall_no_write", 64'(wr_count - wc0), 64'd0);
      if (c < 5) @(negedge clk);
    end
    @(posedge clk);
    #1 wr_ready = 1'b1;
    @(negedge clk);
    for (int i = 4; i < 8; i++) send_byte(8'(8'h31 + i));
    drain();
    check("stall_words", 64'(wr_count - wc0), 64'd2);
    check("stall_final_addr", 64'(wr_addr), 64'h22);

    // Reset after two of four data bytes: frame is abandoned.
    wc0 = wr_count;
    send_header(I_MEM, 16'h0005, 16'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    check("mid_lanes_loaded", 64'(wr_data[15:0]), 64'hBBAA);
    rst_n = 1'b0;
    #1;
    check("mid_rst_wr_data", 64'(wr_data[63:0]), 64'h0);
    check("mid_rst_wr_addr", 64'(wr_addr), 64'h0);
    check("mid_rst_wr_dest", 64'(wr_dest), 64'h0);
    check("mid_rst_rx_ready", 64'(rx_ready), 64'd1);
    check("mid_rst_wr_en", 64'(wr_en), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(I_MEM, 16'h0007, 16'd1, 8'hC1, 8'h01, 8'hFF);
    drain();
    check("mid_rst_words", 64'(wr_count - wc0), 64'd1);
    check("mid_rst_new_word", 64'(last_data[63:0]), 64'hC4C3_C2C1);

    // End-of-load command: other bits are ignored.
    send_byte(8'h83);
    check("done_set", 64'(done), 64'd1);
    check("done_rx_ready", 64'(rx_ready), 64'd0);
    check("done_err", 64'(err), 64'd0);
    repeat (3) @(negedge clk);
    check("done_sticky", 64'(done), 64'd1);
    check("done_rx_ready_hold", 64'(rx_ready), 64'd0);
    check("done_wr_en", 64'(wr_en), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
